// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined carry-lookahead adder.
// Stage 1 forms bit and 4-bit group generate/propagate terms.
// Stage 2 resolves the group carries, ripples them inside each group and registers the result.
// Optional feature: define CLA_SUB_EN to make sub=1 compute a - b (b inverted, carry-in forced to 1).
// Without CLA_SUB_EN the sub port is ignored and no inversion logic exists.
//
// Handshake (both ports): a transfer happens on a rising clk edge where valid && ready.
// A valid never depends on the matching ready. Once raised, it holds with stable data
// until that transfer happens.
module cla_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NG = WIDTH / GROUP;

    // ---------------- stage 1: operand conditioning and g/p terms ----------------
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef CLA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | c_in;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign cin_eff    = c_in;
`endif

    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] p_bit;
    assign g_bit = a & b_eff;
    assign p_bit = a ^ b_eff;

    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;

    // Group terms are built as a tree of the pairwise combine rule: bits (1,0), (3,2), then the two pairs.
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        logic [3:0] gb;
        logic [3:0] pb;
        logic       g_lo;
        logic       p_lo;
        logic       g_hi;
        logic       p_hi;
        assign gb          = g_bit[gi*4 +: 4];
        assign pb          = p_bit[gi*4 +: 4];
        assign g_lo        = gb[1] | (pb[1] & gb[0]);
        assign p_lo        = pb[1] & pb[0];
        assign g_hi        = gb[3] | (pb[3] & gb[2]);
        assign p_hi        = pb[3] & pb[2];
        assign grp_g[gi]   = g_hi | (p_hi & g_lo);
        assign grp_p[gi]   = p_hi & p_lo;
    end

    // ---------------- pipeline control ----------------
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid | out_ready;
    assign s1_adv   = !s1_valid | s2_adv;
    assign in_ready = s1_adv;

    // Stage-1 registers. Bit g is kept alongside bit p because the in-group ripple of stage 2 needs it.
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NG-1:0]    s1_gg;
    logic [NG-1:0]    s1_gp;
    logic             s1_cin;

    // Stage 1 captures new operands whenever it advances. Without new data it only clears its valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gg    <= '0;
            s1_gp    <= '0;
            s1_cin   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p   <= p_bit;
                s1_g   <= g_bit;
                s1_gg  <= grp_g;
                s1_gp  <= grp_p;
                s1_cin <= cin_eff;
            end
        end
    end

    // ---------------- stage 2: carry resolution and sum ----------------
    logic [NG:0]      grp_c;
    logic [WIDTH:0]   bit_c;
    logic [WIDTH-1:0] sum_nxt;

    // Group carries come from the registered lookahead terms. Each group then ripples its carry-in across its four bits.
    always_comb begin
        grp_c    = '0;
        bit_c    = '0;
        grp_c[0] = s1_cin;
        for (int i = 0; i < NG; i++) begin
            grp_c[i+1] = s1_gg[i] | (s1_gp[i] & grp_c[i]);
        end
        for (int i = 0; i < NG; i++) begin
            bit_c[i*4] = grp_c[i];
            for (int j = 0; j < 3; j++) begin
                bit_c[i*4+j+1] = s1_g[i*4+j] | (s1_p[i*4+j] & bit_c[i*4+j]);
            end
        end
        bit_c[WIDTH] = grp_c[NG];
        sum_nxt      = s1_p ^ bit_c[WIDTH-1:0];
    end

    // The output register loads only when stage 2 advances. The result stays held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum   <= sum_nxt;
                c_out <= grp_c[NG];
                ovf   <= bit_c[WIDTH-1] ^ grp_c[NG];
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Testbench for cla_adder_pipe.
// Directed checks use a 16-bit instance. Random streaming uses the 16-bit instance plus 4-, 32- and 64-bit instances.
// Expected results come from plain W-bit arithmetic on the operands.
module tb_cla_adder_pipe;

`ifdef CLA_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    localparam int NTX = 200;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int   n_checks     = 0;
    int   n_fail       = 0;
    int   rnd_finished = 0;
    logic rnd_go       = 1'b0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference result packed as {ovf, c_out, sum(64 bits, zero above w)}.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] op_a, input logic [63:0] op_b,
                                            input logic ci, input logic sb);
        logic [63:0] mask;
        logic [63:0] av;
        logic [63:0] be;
        logic [63:0] s;
        logic [64:0] full;
        logic        ce;
        logic        co;
        logic        ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        av   = op_a & mask;
        be   = op_b & mask;
        ce   = ci;
        if (SUB_EN && sb) begin
            be = ~op_b & mask;
            ce = 1'b1;
        end
        full = {1'b0, av} + {1'b0, be} + {64'd0, ce};
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = (av[w-1] == be[w-1]) && (s[w-1] != av[w-1]);
        return {ov, co, s};
    endfunction

    // ---------------- 16-bit DUT ----------------
    logic        d_iv, d_ir, d_ci, d_sub, d_ov, d_ordy, d_co, d_ovf;
    logic [15:0] d_a, d_b, d_sum;

    cla_adder_pipe #(.WIDTH(16), .GROUP(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir),
        .a(d_a), .b(d_b), .c_in(d_ci), .sub(d_sub),
        .out_valid(d_ov), .out_ready(d_ordy), .sum(d_sum), .c_out(d_co), .ovf(d_ovf)
    );

    logic [65:0] exp16_q[$];
    int          sent16;
    int          got16;
    logic [15:0] bp_a[4] = '{16'h1111, 16'hFFFF, 16'h8000, 16'h00AA};
    logic [15:0] bp_b[4] = '{16'h2222, 16'h0002, 16'h8000, 16'h5500};

    // ---------------- driver tasks ----------------
    // Caller sits on a negedge. Sends one operand set, then checks latency, result and drain.
    task automatic send_and_check(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb,
                                  input logic [15:0] es, input logic ec, input logic eo, input string tag);
        d_a = x; d_b = y; d_ci = ci; d_sub = sb; d_iv = 1'b1; d_ordy = 1'b1;
        #1 check({tag, "_rdy"}, 66'(d_ir), 66'd1);
        @(negedge clk);
        d_iv = 1'b0;
        #1 check({tag, "_lat1"}, 66'(d_ov), 66'd0);
        @(negedge clk);
        #1 check({tag, "_vld"}, 66'(d_ov), 66'd1);
        check({tag, "_res"}, {d_ovf, d_co, 48'd0, d_sum}, {eo, ec, 48'd0, es});
        @(negedge clk);
        #1 check({tag, "_drain"}, 66'(d_ov), 66'd0);
    endtask

    // One cycle on the 16-bit stream. Drive at negedge, then settle. Log both transfers due at the coming posedge.
    task automatic step16(input logic drv, input logic [15:0] x, input logic [15:0] y, input logic ci,
                          input logic sb, input logic ordy, input string tag);
        @(negedge clk);
        d_iv = drv; d_a = x; d_b = y; d_ci = ci; d_sub = sb; d_ordy = ordy;
        #1;
        if (d_ov && d_ordy) begin
            if (exp16_q.size() == 0) check({tag, "_unexp"}, 66'(d_ov), 66'd0);
            else check(tag, {d_ovf, d_co, 48'd0, d_sum}, exp16_q.pop_front());
            got16++;
        end
        if (d_iv && d_ir) begin
            exp16_q.push_back(ref_add(16, 64'(x), 64'(y), ci, sb));
            sent16++;
        end
    endtask

    // ---------------- random streams at other widths ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int W = (gi == 0) ? 4 : ((gi == 1) ? 32 : 64);
        logic         iv, ir, ov, ordy, ci, sb, co, of;
        logic [W-1:0] xa, xb, xs;
        logic [65:0]  exp_q[$];
        int           sent;
        int           got;

        cla_adder_pipe #(.WIDTH(W), .GROUP(4)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
            .a(xa), .b(xb), .c_in(ci), .sub(sb),
            .out_valid(ov), .out_ready(ordy), .sum(xs), .c_out(co), .ovf(of)
        );

        initial begin
            logic [63:0] r_a;
            logic [63:0] r_b;
            iv = 1'b0; ordy = 1'b1; xa = '0; xb = '0; ci = 1'b0; sb = 1'b0;
            sent = 0; got = 0;
            wait (rnd_go == 1'b1);
            for (int cyc = 0; cyc < 4000 && got < NTX; cyc++) begin
                @(negedge clk);
                r_a = {$urandom(), $urandom()};
                r_b = {$urandom(), $urandom()};
                if ($urandom_range(0, 7) == 0) r_a = '1;
                iv   = (sent < NTX) && ($urandom_range(0, 3) != 0);
                xa   = r_a[W-1:0];
                xb   = r_b[W-1:0];
                ci   = 1'($urandom_range(0, 1));
                sb   = 1'($urandom_range(0, 1));
                ordy = ($urandom_range(0, 3) != 0);
                #1;
                if (ov && ordy) begin
                    if (exp_q.size() == 0) check($sformatf("w%0d_unexp", W), 66'(ov), 66'd0);
                    else check($sformatf("w%0d_res", W), {of, co, 64'(xs)}, exp_q.pop_front());
                    got++;
                end
                if (iv && ir) begin
                    exp_q.push_back(ref_add(W, r_a, r_b, ci, sb));
                    sent++;
                end
            end
            @(negedge clk);
            iv = 1'b0;
            check($sformatf("w%0d_count", W), 66'(got), 66'(NTX));
            rnd_finished++;
        end
    end

    // ---------------- main sequence ----------------
    logic        r_v, r_ci, r_sb, r_rdy;
    logic [15:0] r_a16, r_b16;

    initial begin
        rst_n = 1'b0;
        d_iv = 1'b0; d_a = '0; d_b = '0; d_ci = 1'b0; d_sub = 1'b0; d_ordy = 1'b0;
        sent16 = 0; got16 = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 66'(d_ir), 66'd1);
        check("rst_out_valid", 66'(d_ov), 66'd0);
        check("rst_outputs", {d_ovf, d_co, 48'd0, d_sum}, 66'd0);

        // Release, then offer operands on the very first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        send_and_check(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
        send_and_check(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
        send_and_check(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "cin");
        send_and_check(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
        send_and_check(16'h0005, 16'h0007, 1'b0, 1'b1, SUB_EN ? 16'hFFFE : 16'h000C, 1'b0, 1'b0, "sub");

        // Reset pulse one cycle after an accept discards the transaction.
        d_a = 16'h0F0F; d_b = 16'h0101; d_ci = 1'b0; d_sub = 1'b0; d_iv = 1'b1; d_ordy = 1'b1;
        #1 check("mrst_accept_rdy", 66'(d_ir), 66'd1);
        @(negedge clk);
        d_iv  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_ov_in_rst", 66'(d_ov), 66'd0);
        check("mrst_rdy_in_rst", 66'(d_ir), 66'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("mrst_no_out", 66'(d_ov), 66'd0);
            @(negedge clk);
        end
        send_and_check(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "post_rst");

        // Backpressure: four back-to-back offers with out_ready low for five cycles.
        exp16_q.delete();
        sent16 = 0; got16 = 0;
        for (int cyc = 0; cyc < 40 && got16 < 4; cyc++) begin
            step16(sent16 < 4, (sent16 < 4) ? bp_a[sent16 % 4] : 16'h0, (sent16 < 4) ? bp_b[sent16 % 4] : 16'h0,
                   1'b0, 1'b0, cyc >= 5, "bp");
            if (cyc == 2) begin
                check("bp_in_ready_low", 66'(d_ir), 66'd0);
                check("bp_accepts", 66'(sent16), 66'd2);
            end
            if (cyc >= 2 && cyc < 5) begin
                check("bp_hold_valid", 66'(d_ov), 66'd1);
                check("bp_hold_data", {d_ovf, d_co, 48'd0, d_sum}, ref_add(16, 64'(bp_a[0]), 64'(bp_b[0]), 1'b0, 1'b0));
            end
        end
        check("bp_count", 66'(got16), 66'd4);

        // Random streaming on all widths.
        rnd_go = 1'b1;
        exp16_q.delete();
        sent16 = 0; got16 = 0;
        for (int cyc = 0; cyc < 4000 && got16 < NTX; cyc++) begin
            r_v   = (sent16 < NTX) && ($urandom_range(0, 3) != 0);
            r_a16 = 16'($urandom());
            r_b16 = 16'($urandom());
            r_ci  = 1'($urandom_range(0, 1));
            r_sb  = 1'($urandom_range(0, 1));
            r_rdy = ($urandom_range(0, 3) != 0);
            step16(r_v, r_a16, r_b16, r_ci, r_sb, r_rdy, "w16_res");
        end
        @(negedge clk);
        d_iv = 1'b0;
        check("w16_count", 66'(got16), 66'(NTX));

        for (int i = 0; i < 6000 && rnd_finished < 3; i++) @(negedge clk);
        check("rnd_all_done", 66'(rnd_finished), 66'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
